// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 1-way data cache and its miss/refill controller.
//   miss_state_t : controller FSM encoding (IDLE, REQ, WAIT, DONE)
//   CACHE_AW, CACHE_SET_BITS : default address width and index width
//   OFFSET_BITS, SET_LSB     : byte-offset width / lowest index bit
//   TAG_BITS                 : tag width for the default geometry
//   tag_lsb()                : lowest tag bit for a given index width
// -----------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } miss_state_t;

  localparam int CACHE_AW       = 32;
  localparam int CACHE_SET_BITS = 3;
  localparam int OFFSET_BITS    = 2;
  localparam int SET_LSB        = OFFSET_BITS;
  localparam int TAG_BITS       = CACHE_AW - CACHE_SET_BITS - OFFSET_BITS;

  function automatic int tag_lsb(input int set_bits);
    return SET_LSB + set_bits;
  endfunction

endpackage

// File: rtl/cache_stat_ctr.sv
// -----------------------------------------------------------------------------
// cache_stat_ctr
// Saturating event counter; holds at all-ones instead of wrapping.
// Ports:
//   clk   : clock, rising edge
//   rst_n : async active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current count
// -----------------------------------------------------------------------------
module cache_stat_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (inc) count <= sat_inc(count);
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_ctrl
// Miss/refill controller between a 1-way, 1-word-line data cache and data
// memory. Load hits return cache data with no stall; load misses stall, fetch
// the word over a valid/ready request + response and refill the cache. Stores
// are write-through / no-write-allocate and update the cache only on a hit.
//
// Optional feature: define CACHE_MISS_STATS_EN to add saturating 32-bit
// stat_hits / stat_misses counters (IDLE load hits / load misses).
//
// Ports:
//   clk, rst_n                    : clock (rising), async active-low reset
//   cpu_req_valid/we/addr/wdata   : CPU load/store request
//   cache_hit, cache_rdata        : cache lookup result for cpu_addr
//   cpu_stall                     : pipeline freeze (combinational)
//   cpu_rdata, cpu_rdata_valid    : load result
//   mem_req_valid/ready/we/addr/wdata : memory request handshake
//   mem_rsp_valid, mem_rsp_data   : memory read response (1-cycle pulse)
//   fill_en/set/tag/data          : cache line write
//   stat_hits, stat_misses        : (CACHE_MISS_STATS_EN only) counters
// -----------------------------------------------------------------------------
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter  int ADDRESS_WIDTH = CACHE_AW,
  parameter  int DATA_WIDTH    = 32,
  parameter  int SET_BITS      = CACHE_SET_BITS,
  localparam int TAG_W         = ADDRESS_WIDTH - SET_BITS - OFFSET_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req_valid,
  input  logic                     cpu_req_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic                     cache_hit,
  input  logic [DATA_WIDTH-1:0]    cache_rdata,
  output logic                     cpu_stall,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_rdata_valid,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]    mem_req_wdata,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rsp_data,
  output logic                     fill_en,
  output logic [SET_BITS-1:0]      fill_set,
  output logic [TAG_W-1:0]         fill_tag,
  output logic [DATA_WIDTH-1:0]    fill_data
`ifdef CACHE_MISS_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = {{(ADDRESS_WIDTH-OFFSET_BITS){1'b1}},
                                                    {OFFSET_BITS{1'b0}}};

  miss_state_t state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     we_q;
  logic                     hit_q;
  logic [DATA_WIDTH-1:0]    rsp_q;

  // A request needs the memory side when it is a store (write-through) or a load miss.
  logic start_txn;
  assign start_txn = (state == IDLE) && cpu_req_valid && (cpu_req_we || !cache_hit);

  // ---- state and transaction registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state <= state_nxt;
      if (start_txn) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        we_q    <= cpu_req_we;
        hit_q   <= cache_hit;
      end
      if ((state == WAIT) && mem_rsp_valid) rsp_q <= mem_rsp_data;
    end
  end

  // Request and fill address fields come straight from the latched request, so
  // they stay stable for the whole handshake.
  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q & WORD_MASK;
  assign mem_req_wdata = wdata_q;
  assign fill_set      = addr_q[SET_LSB +: SET_BITS];
  assign fill_tag      = addr_q[tag_lsb(SET_BITS) +: TAG_W];

  // ---- next state and outputs ----
  always_comb begin
    state_nxt       = state;
    cpu_stall       = 1'b0;
    cpu_rdata       = '0;
    cpu_rdata_valid = 1'b0;
    mem_req_valid   = 1'b0;
    fill_en         = 1'b0;
    fill_data       = '0;
    case (state)
      IDLE: begin
        if (cpu_req_valid) begin
          if (!cpu_req_we && cache_hit) begin
            cpu_rdata       = cache_rdata;
            cpu_rdata_valid = 1'b1;
          end else begin
            cpu_stall = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        cpu_stall     = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = we_q ? DONE : WAIT;
      end
      WAIT: begin
        cpu_stall = 1'b1;
        if (mem_rsp_valid) state_nxt = DONE;
      end
      DONE: begin
        // The request visible now is the one completing; it is not restarted.
        state_nxt = IDLE;
        if (!we_q) begin
          cpu_rdata       = rsp_q;
          cpu_rdata_valid = 1'b1;
          fill_en         = 1'b1;
          fill_data       = rsp_q;
        end else if (hit_q) begin
          fill_en   = 1'b1;
          fill_data = wdata_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CACHE_MISS_STATS_EN
  logic hit_evt, miss_evt;
  assign hit_evt  = (state == IDLE) && cpu_req_valid && !cpu_req_we &&  cache_hit;
  assign miss_evt = (state == IDLE) && cpu_req_valid && !cpu_req_we && !cache_hit;

  cache_stat_ctr #(.W(32)) u_hits (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_evt),
    .count (stat_hits)
  );

  cache_stat_ctr #(.W(32)) u_misses (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_evt),
    .count (stat_misses)
  );
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
module tb_cache_miss_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rdata_valid;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        fill_en;
  logic [2:0]  fill_set;
  logic [26:0] fill_tag;
  logic [31:0] fill_data;
`ifdef CACHE_MISS_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int compares = 0;
  int errs     = 0;

  cache_miss_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_we      (cpu_req_we),
    .cpu_addr        (cpu_addr),
    .cpu_wdata       (cpu_wdata),
    .cache_hit       (cache_hit),
    .cache_rdata     (cache_rdata),
    .cpu_stall       (cpu_stall),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data),
    .fill_en         (fill_en),
    .fill_set        (fill_set),
    .fill_tag        (fill_tag),
    .fill_data       (fill_data)
`ifdef CACHE_MISS_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic cpu_idle();
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;
    cache_hit     = 1'b0;
    cache_rdata   = '0;
  endtask

  initial begin
    rst_n         = 1'b0;
    cpu_idle();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;

    // Reset state
    tick(); tick(); settle();
    chk("rst_stall",     {63'd0, cpu_stall},       64'd0);
    chk("rst_memvalid",  {63'd0, mem_req_valid},   64'd0);
    chk("rst_fill",      {63'd0, fill_en},         64'd0);
    chk("rst_rvalid",    {63'd0, cpu_rdata_valid}, 64'd0);
    chk("rst_memaddr",   {32'd0, mem_req_addr},    64'd0);
    tick(); rst_n = 1'b1;

    // 1: load hit
    tick();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cache_hit = 1'b1;
    cpu_addr = 32'h0000_0010; cache_rdata = 32'hDEAD_BEEF;
    settle();
    chk("hit_rvalid",   {63'd0, cpu_rdata_valid}, 64'd1);
    chk("hit_rdata",    {32'd0, cpu_rdata},       64'hDEAD_BEEF);
    chk("hit_stall",    {63'd0, cpu_stall},       64'd0);
    chk("hit_memvalid", {63'd0, mem_req_valid},   64'd0);

    // 2: load miss, ready=1, rsp in the second WAIT cycle
    tick();
    cache_hit = 1'b0; cache_rdata = 32'h1111_1111; cpu_addr = 32'h0000_0014;
    mem_req_ready = 1'b1;
    settle();
    chk("lm_idle_stall",  {63'd0, cpu_stall},       64'd1);
    chk("lm_idle_rvalid", {63'd0, cpu_rdata_valid}, 64'd0);
    tick(); settle();
    chk("lm_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("lm_req_addr",  {32'd0, mem_req_addr},  64'h14);
    chk("lm_req_we",    {63'd0, mem_req_we},    64'd0);
    chk("lm_req_stall", {63'd0, cpu_stall},     64'd1);
    tick(); settle();
    chk("lm_wait1_stall", {63'd0, cpu_stall},     64'd1);
    chk("lm_wait1_mreq",  {63'd0, mem_req_valid}, 64'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    settle();
    chk("lm_wait2_stall", {63'd0, cpu_stall}, 64'd1);
    chk("lm_wait2_fill",  {63'd0, fill_en},   64'd0);
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    settle();
    chk("lm_done_stall",  {63'd0, cpu_stall},       64'd0);
    chk("lm_done_rvalid", {63'd0, cpu_rdata_valid}, 64'd1);
    chk("lm_done_rdata",  {32'd0, cpu_rdata},       64'h1234_5678);
    chk("lm_done_fill",   {63'd0, fill_en},         64'd1);
    chk("lm_done_set",    {61'd0, fill_set},        64'd5);
    chk("lm_done_tag",    {37'd0, fill_tag},        64'd0);
    chk("lm_done_fdata",  {32'd0, fill_data},       64'h1234_5678);
    tick();
    cpu_idle(); mem_req_ready = 1'b0;
    settle();
    chk("lm_after_stall", {63'd0, cpu_stall},     64'd0);
    chk("lm_after_mreq",  {63'd0, mem_req_valid}, 64'd0);

    // 3a: store hit, ready low for 3 REQ cycles
    tick();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cache_hit = 1'b1;
    cpu_addr = 32'h0000_0008; cpu_wdata = 32'hA5A5_A5A5;
    settle();
    chk("sh_idle_stall", {63'd0, cpu_stall}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      cache_hit = 1'b0;          // must be ignored outside IDLE
      mem_req_ready = (i == 3);
      settle();
      chk("sh_req_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("sh_req_addr",  {32'd0, mem_req_addr},  64'h8);
      chk("sh_req_we",    {63'd0, mem_req_we},    64'd1);
      chk("sh_req_wdata", {32'd0, mem_req_wdata}, 64'hA5A5_A5A5);
      chk("sh_req_stall", {63'd0, cpu_stall},     64'd1);
    end
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk("sh_done_stall",  {63'd0, cpu_stall},       64'd0);
    chk("sh_done_fill",   {63'd0, fill_en},         64'd1);
    chk("sh_done_fdata",  {32'd0, fill_data},       64'hA5A5_A5A5);
    chk("sh_done_set",    {61'd0, fill_set},        64'd2);
    chk("sh_done_rvalid", {63'd0, cpu_rdata_valid}, 64'd0);
    tick();
    cpu_idle();

    // 3b: store miss -> no fill
    tick();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cache_hit = 1'b0;
    cpu_addr = 32'h0000_0008; cpu_wdata = 32'h5A5A_5A5A;
    mem_req_ready = 1'b1;
    settle();
    chk("sm_idle_stall", {63'd0, cpu_stall}, 64'd1);
    tick();
    cache_hit = 1'b1;            // must be ignored outside IDLE
    settle();
    chk("sm_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("sm_req_wdata", {32'd0, mem_req_wdata}, 64'h5A5A_5A5A);
    tick(); settle();
    chk("sm_done_stall", {63'd0, cpu_stall}, 64'd0);
    chk("sm_done_fill",  {63'd0, fill_en},   64'd0);
    tick();
    cpu_idle(); mem_req_ready = 1'b0;

    // 4: stray responses in IDLE and REQ
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0BAD;
    settle();
    chk("st_idle_fill",  {63'd0, fill_en},       64'd0);
    chk("st_idle_stall", {63'd0, cpu_stall},     64'd0);
    chk("st_idle_mreq",  {63'd0, mem_req_valid}, 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cache_hit = 1'b0; cpu_addr = 32'h0000_0040;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0BAD;
    settle();
    chk("st_req_mreq", {63'd0, mem_req_valid}, 64'd1);
    chk("st_req_fill", {63'd0, fill_en},       64'd0);
    tick(); settle();
    chk("st_req2_mreq", {63'd0, mem_req_valid}, 64'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    settle();
    chk("st_wait_mreq",  {63'd0, mem_req_valid}, 64'd0);
    chk("st_wait_stall", {63'd0, cpu_stall},     64'd1);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("st_done_rdata", {32'd0, cpu_rdata}, 64'hCAFE_F00D);
    chk("st_done_set",   {61'd0, fill_set},  64'd0);
    chk("st_done_tag",   {37'd0, fill_tag},  64'd2);
    tick();
    cpu_idle();

    // 5: reset during WAIT
    tick();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cache_hit = 1'b0; cpu_addr = 32'h0000_001C;
    mem_req_ready = 1'b1;
    tick();
    tick();
    settle();
    chk("ra_wait_stall", {63'd0, cpu_stall}, 64'd1);
    #2;
    rst_n = 1'b0; cpu_idle(); mem_req_ready = 1'b0;
    #1;
    chk("ra_stall",    {63'd0, cpu_stall},       64'd0);
    chk("ra_mreq",     {63'd0, mem_req_valid},   64'd0);
    chk("ra_fill",     {63'd0, fill_en},         64'd0);
    chk("ra_rvalid",   {63'd0, cpu_rdata_valid}, 64'd0);
    chk("ra_memaddr",  {32'd0, mem_req_addr},    64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0077;
    settle();
    chk("ra_late_fill",   {63'd0, fill_en},         64'd0);
    chk("ra_late_rvalid", {63'd0, cpu_rdata_valid}, 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cache_hit = 1'b0; cpu_addr = 32'h0000_0024;
    mem_req_ready = 1'b1;
    settle();
    chk("rb_idle_stall", {63'd0, cpu_stall}, 64'd1);
    tick(); settle();
    chk("rb_req_addr", {32'd0, mem_req_addr}, 64'h24);
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h600D_F00D;
    settle();
    chk("rb_wait_stall", {63'd0, cpu_stall}, 64'd1);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("rb_done_rvalid", {63'd0, cpu_rdata_valid}, 64'd1);
    chk("rb_done_rdata",  {32'd0, cpu_rdata},       64'h600D_F00D);
    chk("rb_done_set",    {61'd0, fill_set},        64'd1);
    chk("rb_done_tag",    {37'd0, fill_tag},        64'd1);
    tick();
    cpu_idle(); mem_req_ready = 1'b0;

`ifdef CACHE_MISS_STATS_EN
    // 6: statistics
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("stat_rst_hits", {32'd0, stat_hits}, 64'd0);
    mem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cache_hit = 1'b1; cpu_addr = 32'h100 + 32'(i * 4);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cache_hit = 1'b0; cpu_addr = 32'h200 + 32'(i * 4);
      tick();                      // REQ
      tick();                      // WAIT
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1;
      tick();                      // DONE
      mem_rsp_valid = 1'b0;
    end
    tick();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cache_hit = 1'b0; cpu_addr = 32'h300;
    tick();                        // REQ
    tick();                        // DONE
    tick();
    cpu_idle(); mem_req_ready = 1'b0;
    settle();
    chk("stat_hits",   {32'd0, stat_hits},   64'd3);
    chk("stat_misses", {32'd0, stat_misses}, 64'd2);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errs);
    $finish;
  end

endmodule
